// File: rtl/logc_pkg.sv
// Shared widths, log2 mantissa table and saturation constant for the logc chain.
// Table entries are built at elaboration time from LUT_BITS/FRAC_BITS.
// No logic of its own; only constants and a table-read helper.
package logc_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 4;
    localparam int FRAC_BITS   = 8;
    localparam int LUT_BITS    = 5;
    localparam int OUT_WIDTH   = 8;
    localparam int GAIN_SHIFT  = 8;
    localparam int GAIN_WIDTH  = 8;

    localparam int LOG_WIDTH   = SHIFT_WIDTH + FRAC_BITS;
    localparam int R_WIDTH     = DATA_WIDTH - 1 - LUT_BITS;
    localparam int LUT_WIDTH   = FRAC_BITS + 1;
    localparam int LUT_ENTRIES = (1 << LUT_BITS) + 1;
    localparam int LUT_GUARD   = 12;

    localparam logic [OUT_WIDTH-1:0] PIX_MAX = {OUT_WIDTH{1'b1}};

    // round(2^FRAC_BITS * log2(1 + k/2^LUT_BITS)) by repeated squaring in Q2.30
    function automatic logic [LUT_WIDTH-1:0] lut_entry(input int k);
        logic [63:0] x;
        int          ip;
        int          acc;
        x  = 64'((1 << LUT_BITS) + k) << (30 - LUT_BITS);
        ip = 0;
        if (x >= (64'd2 << 30)) begin
            ip = 1;
            x  = x >> 1;
        end
        acc = 0;
        for (int i = 0; i < FRAC_BITS + LUT_GUARD; i++) begin
            x   = (x * x) >> 30;
            acc = acc * 2;
            if (x >= (64'd2 << 30)) begin
                acc = acc + 1;
                x   = x >> 1;
            end
        end
        return LUT_WIDTH'((ip << FRAC_BITS) + ((acc + (1 << (LUT_GUARD - 1))) >> LUT_GUARD));
    endfunction

    function automatic logic [LUT_ENTRIES*LUT_WIDTH-1:0] gen_lut();
        logic [LUT_ENTRIES*LUT_WIDTH-1:0] t;
        t = '0;
        for (int k = 0; k < LUT_ENTRIES; k++)
            t[k*LUT_WIDTH +: LUT_WIDTH] = lut_entry(k);
        return t;
    endfunction

    localparam logic [LUT_ENTRIES*LUT_WIDTH-1:0] LUT_FLAT = gen_lut();

    function automatic logic [LUT_WIDTH-1:0] lut_read(input logic [LUT_BITS:0] k);
        return LUT_FLAT[int'(k)*LUT_WIDTH +: LUT_WIDTH];
    endfunction
endpackage

// File: rtl/log2_interp.sv
// log2 of a normalised sample: S1 splits index/remainder and reads the table, S2 interpolates.
// Latency 2 cycles from sample_valid to log_valid.
// Both stages advance only while en is high; otherwise they hold.
module log2_interp
    import logc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   sample_valid,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   log_valid,
    output logic [LOG_WIDTH-1:0]   log_val
);
    logic                         s1_valid;
    logic [LUT_WIDTH-1:0]         s1_lo;
    logic [LUT_WIDTH-1:0]         s1_hi;
    logic [R_WIDTH-1:0]           s1_r;
    logic [SHIFT_WIDTH-1:0]       s1_e;

    logic [SHIFT_WIDTH-1:0]       shift_c;
    logic [LUT_BITS:0]            idx;
    logic [LUT_WIDTH+R_WIDTH-1:0] prod;
    logic [LUT_WIDTH-1:0]         frac;

    always_comb begin
        shift_c = (int'(shift) > DATA_WIDTH - 1) ? SHIFT_WIDTH'(DATA_WIDTH - 1) : shift;
        idx     = {1'b0, data[DATA_WIDTH-2 -: LUT_BITS]};
        prod    = (LUT_WIDTH+R_WIDTH)'(s1_hi - s1_lo) * (LUT_WIDTH+R_WIDTH)'(s1_r);
        frac    = s1_lo + LUT_WIDTH'(prod >> R_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            log_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= sample_valid;
            log_valid <= s1_valid;
        end
    end

    // An un-normalised sample (MSB clear, including zero) is forced to log 0.
    always_ff @(posedge clk) begin
        if (en && sample_valid) begin
            if (data[DATA_WIDTH-1]) begin
                s1_lo <= lut_read(idx);
                s1_hi <= lut_read(idx + (LUT_BITS+1)'(1));
                s1_r  <= data[R_WIDTH-1:0];
                s1_e  <= SHIFT_WIDTH'(DATA_WIDTH - 1) - shift_c;
            end else begin
                s1_lo <= '0;
                s1_hi <= '0;
                s1_r  <= '0;
                s1_e  <= '0;
            end
        end
        // frac tops out at 2^FRAC_BITS-1, so the add is a plain concatenation
        if (en && s1_valid)
            log_val <= {s1_e, {FRAC_BITS{1'b0}}} + LOG_WIDTH'(frac);
    end
endmodule

// File: rtl/log_compress.sv
// Log compression: log2 via table interpolation, then floor/gain/saturate to a pixel; LOGC_CLIP_STATS_EN adds clip counters.
// Latency 3 cycles from input handshake to out_valid, 1 sample/cycle.
// One global advance (out idle or out_ready) drives in_ready; a stalled output freezes every stage.
module log_compress
    import logc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0] shift_amt,
    input  logic [LOG_WIDTH-1:0]   dr_offset,
    input  logic [GAIN_WIDTH-1:0]  gain,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   pix_out,
    output logic [LOG_WIDTH-1:0]   log_out
`ifdef LOGC_CLIP_STATS_EN
    ,
    output logic [15:0]            clip_hi_cnt,
    output logic [15:0]            clip_lo_cnt
`endif
);
    localparam int PROD_WIDTH = LOG_WIDTH + GAIN_WIDTH;

    logic                  adv;
    logic                  s2_valid;
    logic [LOG_WIDTH-1:0]  s2_log;
    logic                  floor_hit;
    logic                  sat_hit;
    logic [PROD_WIDTH-1:0] scaled;
    logic [OUT_WIDTH-1:0]  pix_c;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    log2_interp u_interp (
        .clk          (clk),
        .reset        (reset),
        .en           (adv),
        .sample_valid (in_valid),
        .data         (data_in),
        .shift        (shift_amt),
        .log_valid    (s2_valid),
        .log_val      (s2_log)
    );

    always_comb begin
        floor_hit = (s2_log <= dr_offset);
        scaled    = (PROD_WIDTH'(s2_log - dr_offset) * PROD_WIDTH'(gain)) >> GAIN_SHIFT;
        sat_hit   = !floor_hit && (scaled > PROD_WIDTH'(PIX_MAX));
        if (floor_hit)
            pix_c = '0;
        else if (sat_hit)
            pix_c = PIX_MAX;
        else
            pix_c = scaled[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            pix_out   <= '0;
            log_out   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                pix_out <= pix_c;
                log_out <= s2_log;
            end
        end
    end

`ifdef LOGC_CLIP_STATS_EN
    logic clip_hi_q;
    logic clip_lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_hi_q   <= 1'b0;
            clip_lo_q   <= 1'b0;
            clip_hi_cnt <= '0;
            clip_lo_cnt <= '0;
        end else begin
            if (adv && s2_valid) begin
                clip_hi_q <= sat_hit;
                clip_lo_q <= floor_hit;
            end
            if (out_valid && out_ready && clip_hi_q && clip_hi_cnt != 16'hFFFF)
                clip_hi_cnt <= clip_hi_cnt + 16'd1;
            if (out_valid && out_ready && clip_lo_q && clip_lo_cnt != 16'hFFFF)
                clip_lo_cnt <= clip_lo_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_log_compress.sv
// Bench for log_compress: directed table, backpressure, throughput, random stress, mid-stream reset.
module tb_log_compress;
    import logc_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic [LOG_WIDTH-1:0]   dr_offset;
    logic [GAIN_WIDTH-1:0]  gain;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   pix_out;
    logic [LOG_WIDTH-1:0]   log_out;
`ifdef LOGC_CLIP_STATS_EN
    logic [15:0]            clip_hi_cnt;
    logic [15:0]            clip_lo_cnt;
`endif

    always #5 clk = ~clk;

    log_compress dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .dr_offset (dr_offset),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix_out   (pix_out),
        .log_out   (log_out)
`ifdef LOGC_CLIP_STATS_EN
        ,
        .clip_hi_cnt (clip_hi_cnt),
        .clip_lo_cnt (clip_lo_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lut_ref [0:LUT_ENTRIES-1];
    int cyc       = 0;
    int out_count = 0;
    int first_out = -1;
    int last_out  = -1;

    typedef struct { int l; int p; } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
        int          off;
        int          g;
        int          l;
        int          pix;
        bit          hi;
        bit          lo;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: log2 via real-valued table, interpolation as plain integer arithmetic.
    function automatic int ref_log(input int d, input int s);
        int e, m, idx, r, frac;
        if (((d >> (DATA_WIDTH - 1)) & 1) == 0) return 0;
        e    = (DATA_WIDTH - 1) - ((s > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : s);
        m    = d & ((1 << (DATA_WIDTH - 1)) - 1);
        idx  = m >> R_WIDTH;
        r    = m & ((1 << R_WIDTH) - 1);
        frac = lut_ref[idx] + ((lut_ref[idx+1] - lut_ref[idx]) * r) / (1 << R_WIDTH);
        return e * (1 << FRAC_BITS) + frac;
    endfunction

    function automatic int ref_pix(input int l, input int off, input int g);
        int v;
        if (l <= off) return 0;
        v = ((l - off) * g) / (1 << GAIN_SHIFT);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 3) != 0) d[15] = 1'b1;
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expectations formed at input handshake, compared at output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                out_count++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: unexpected pixel %0d, expected none", pix_out);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_log", int'(log_out), sb_e.l);
                    check("sb_pix", int'(pix_out), sb_e.p);
                end
            end
            if (in_valid && in_ready) begin
                sb_e.l = ref_log(int'(data_in), int'(shift_amt));
                sb_e.p = ref_pix(sb_e.l, int'(dr_offset), int'(gain));
                exp_q.push_back(sb_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, t, i, bp_before, start_cyc, stalls, seen, hold_pix, hold_log;
        bit acc, stall_seen;
        logic [15:0] bp_d [8];
        logic [3:0]  bp_s [8];
`ifdef LOGC_CLIP_STATS_EN
        int hi0, lo0;
`endif

        for (int k = 0; k < LUT_ENTRIES; k++)
            lut_ref[k] = $rtoi(256.0 * $ln(1.0 + real'(k) / 32.0) / $ln(2.0) + 0.5);

        vecs[0]  = '{16'h8000, 4'd0,  0,    16,  3840, 240, 1'b0, 1'b0};
        vecs[1]  = '{16'hC000, 4'd8,  0,    16,  1942, 121, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 4'd15, 0,    16,  0,    0,   1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 4'd0,  0,    16,  0,    0,   1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 4'd0,  1024, 16,  3840, 176, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 4'd12, 1024, 16,  768,  0,   1'b0, 1'b1};
        vecs[6]  = '{16'h8000, 4'd0,  0,    32,  3840, 255, 1'b1, 1'b0};
        vecs[7]  = '{16'hFFFF, 4'd0,  0,    16,  4095, 255, 1'b0, 1'b0};
        vecs[8]  = '{16'h4000, 4'd3,  0,    16,  0,    0,   1'b0, 1'b1};
        vecs[9]  = '{16'h8000, 4'd0,  3840, 255, 3840, 0,   1'b0, 1'b1};
        vecs[10] = '{16'hA000, 4'd4,  0,    16,  2898, 181, 1'b0, 1'b0};
        vecs[11] = '{16'h8200, 4'd0,  3800, 64,  3845, 11,  1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; data_in = '0; shift_amt = '0;
        dr_offset = '0; gain = 8'd16; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pix", int'(pix_out), 0);
        check("rst_log", int'(log_out), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef LOGC_CLIP_STATS_EN
        check("rst_clip_hi", int'(clip_hi_cnt), 0);
        check("rst_clip_lo", int'(clip_lo_cnt), 0);
`endif
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // Directed table: one sample at a time, latency and values
        for (int v = 0; v < 12; v++) begin
            dr_offset = 12'(vecs[v].off);
            gain      = 8'(vecs[v].g);
`ifdef LOGC_CLIP_STATS_EN
            hi0 = int'(clip_hi_cnt);
            lo0 = int'(clip_lo_cnt);
`endif
            in_valid = 1'b1; data_in = vecs[v].d; shift_amt = vecs[v].s;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", v), lat, 3);
            check($sformatf("vec%0d_log", v), int'(log_out), vecs[v].l);
            check($sformatf("vec%0d_pix", v), int'(pix_out), vecs[v].pix);
            tick();
`ifdef LOGC_CLIP_STATS_EN
            check($sformatf("vec%0d_clip_hi", v), int'(clip_hi_cnt) - hi0, int'(vecs[v].hi));
            check($sformatf("vec%0d_clip_lo", v), int'(clip_lo_cnt) - lo0, int'(vecs[v].lo));
`endif
        end

        // Backpressure: 8 samples, out_ready low from cycle 4 to 13
        dr_offset = '0; gain = 8'd16;
        for (int k = 0; k < 8; k++) begin
            bp_d[k] = rand_sample();
            bp_s[k] = 4'($urandom_range(0, 15));
        end
        bp_before = out_count; i = 0; t = 0; stall_seen = 1'b0; hold_pix = 0; hold_log = 0;
        while ((i < 8 || out_count - bp_before < 8) && t < 100) begin
            in_valid  = (i < 8);
            data_in   = (i < 8) ? bp_d[i] : 16'h0;
            shift_amt = (i < 8) ? bp_s[i] : 4'h0;
            out_ready = (t < 4 || t >= 14);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                check("bp_in_ready_low", int'(in_ready), 0);
                if (stall_seen) begin
                    check("bp_pix_hold", int'(pix_out), hold_pix);
                    check("bp_log_hold", int'(log_out), hold_log);
                end else begin
                    stall_seen = 1'b1;
                    hold_pix = int'(pix_out);
                    hold_log = int'(log_out);
                end
            end
            @(posedge clk);
            #1;
            if (acc) i++;
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_stall_seen", int'(stall_seen), 1);
        check("bp_out_count", out_count - bp_before, 8);
        check("bp_queue_empty", exp_q.size(), 0);

        // Throughput: 64 back-to-back samples
        dr_offset = 12'($urandom_range(0, 2048));
        gain      = 8'($urandom_range(1, 255));
        tick();
        bp_before = out_count; first_out = -1; stalls = 0; start_cyc = cyc;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1; data_in = rand_sample(); shift_amt = 4'($urandom_range(0, 15));
            #1;
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("tp_in_ready_stalls", stalls, 0);
        check("tp_out_count", out_count - bp_before, 64);
        check("tp_first_latency", first_out - start_cyc, 3);
        check("tp_span", last_out - first_out, 63);

        // Random stress with random flow control
        for (int round = 0; round < 3; round++) begin
            dr_offset = 12'($urandom_range(0, 4095));
            gain      = 8'($urandom_range(0, 255));
            for (int k = 0; k < 80; k++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                data_in   = rand_sample();
                shift_amt = 4'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 9) < 7);
                tick();
            end
            in_valid = 1'b0; out_ready = 1'b1;
            t = 0;
            while (exp_q.size() != 0 && t < 20) begin
                tick();
                t++;
            end
            check($sformatf("stress%0d_drained", round), exp_q.size(), 0);
        end

        // Reset with three samples in flight
        dr_offset = '0; gain = 8'd16; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; data_in = 16'h8000; shift_amt = 4'd0;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_rst_out_valid", int'(out_valid), 1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_pix", int'(pix_out), 0);
        check("midrst_log", int'(log_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        reset = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/log_compress.md
Name: log_compress

Overview:
- Log-compression stage directly downstream of the sample normaliser in the ultrasound logc chain.
- Consumes a normalised magnitude (MSB set) plus its left-shift count.
- Computes log2 of the original sample in unsigned fixed point, using a LUT with linear interpolation.
- Applies dynamic-range offset and gain, saturates, and emits a display pixel.
- Fully pipelined with valid/ready handshakes on both sides; throughput 1 sample/cycle.

Parameters:
- DATA_WIDTH, 16, width of the normalised input sample.
- SHIFT_WIDTH, 4, width of shift_amt; equals clog2(DATA_WIDTH).
- FRAC_BITS, 8, fractional bits of the log2 result.
- LUT_BITS, 5, index bits into the log2 mantissa table (2^LUT_BITS+1 entries).
- OUT_WIDTH, 8, pixel width.
- GAIN_SHIFT, 8, right shift applied after the gain multiply.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  stage can accept a sample.
- data_in  input  DATA_WIDTH  normalised sample; bit DATA_WIDTH-1 expected set.
- shift_amt  input  SHIFT_WIDTH  left shift applied upstream.
- dr_offset  input  SHIFT_WIDTH+FRAC_BITS  log-domain floor, quasi-static.
- gain  input  8  unsigned gain, quasi-static.
- out_valid  output  1  pixel valid.
- out_ready  input  1  downstream accepts.
- pix_out  output  OUT_WIDTH  compressed pixel.
- log_out  output  SHIFT_WIDTH+FRAC_BITS  raw log2 value L, aligned with pix_out.

Behaviour:
- Pipeline: three register stages S1/S2/S3, each with its own valid bit. S3 drives the outputs. Latency is 3 cycles from input handshake to out_valid.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - A sample is accepted when in_valid && in_ready.
  - Bubbles propagate; they are not collapsed.
- Stall: while out_valid && !out_ready, all stages hold, and pix_out/log_out are stable.
- S1 (capture):
  - e = DATA_WIDTH-1-shift_amt.
  - m = data_in[DATA_WIDTH-2:0].
  - idx = top LUT_BITS of m; r = remaining DATA_WIDTH-1-LUT_BITS bits.
  - Register LUT[idx], LUT[idx+1], r and e.
- LUT: LUT[k] = round(2^FRAC_BITS * log2(1 + k/2^LUT_BITS)) for k = 0..2^LUT_BITS, so LUT[0]=0 and LUT[32]=256. The table is constant.
- S2 (interpolate):
  - frac = LUT[idx] + (((LUT[idx+1]-LUT[idx]) * r) >> width(r)), truncating.
  - frac never exceeds 2^FRAC_BITS-1.
  - L = {e, frac}.
- S3 (scale):
  - If L <= dr_offset, pix = 0.
  - Otherwise pix = ((L-dr_offset)*gain) >> GAIN_SHIFT, saturated to 2^OUT_WIDTH-1.
  - Compute at full width; no intermediate wrap.
- Special inputs:
  - data_in == 0, or bit DATA_WIDTH-1 clear: forces L=0 and pix=0. Shift is ignored.
  - shift_amt > DATA_WIDTH-1 (unreachable at default widths): treated as DATA_WIDTH-1.
- dr_offset and gain are sampled at S3 entry. A change mid-stream applies to the samples that reach S3 from that cycle on.
- Reset:
  - Clears all valid bits, out_valid=0, pix_out=0, log_out=0.
  - In-flight samples are discarded.
  - in_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro: LOGC_CLIP_STATS_EN.
- When defined, the block adds two output ports, clip_hi_cnt[15:0] and clip_lo_cnt[15:0].
  - clip_hi_cnt counts pixels saturated high at S3 handshake-out (out_valid && out_ready).
  - clip_lo_cnt counts pixels forced to 0 by the floor at the same point.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined, the ports and logic are absent, and pixel behaviour is identical.

Decomposition:
- Package logc_pkg holds:
  - width constants: log width = SHIFT_WIDTH+FRAC_BITS;
  - the LUT as a constant function/array generated from LUT_BITS/FRAC_BITS;
  - the saturation helper constant for OUT_WIDTH.
- One sub-module, log2_interp: stages S1–S2 (index split, LUT read, interpolate), with a valid-in/enable interface.
- The top level owns handshaking, S3 scaling and the stats counters.

Test Plan:
- Directed values, with dr_offset=0, gain=16:
  - data_in=0x8000, shift_amt=0 -> log_out=0xF00, pix_out=240, three cycles after accept.
  - data_in=0xC000, shift_amt=8 -> L=7*256+150=1942 (0x796), pix_out=121.
  - data_in=0x8000, shift_amt=15 -> L=0, pix_out=0.
  - data_in=0 -> L=0, pix_out=0.
- Floor and saturation:
  - dr_offset=1024, gain=16, input 0x8000/shift 0 -> pix_out=176.
  - Input 0x8000/shift 12 (L=768) -> pix_out=0, clip_lo_cnt=1 (with LOGC_CLIP_STATS_EN).
  - gain=32, dr_offset=0, input 0x8000/shift 0 -> 480 saturates to pix_out=255, clip_hi_cnt=1.
- Backpressure:
  - Stream 8 consecutive samples with out_ready held low from cycle 4.
  - in_ready drops once out_valid is high; pix_out stays stable.
  - On release, all 8 pixels emerge in order with no loss or duplication.
- Throughput: in_valid and out_ready held high for 64 samples -> one pixel per cycle after 3-cycle fill, matching a reference model.
- Reset mid-stream: assert reset with 3 samples in flight -> next cycle out_valid=0, pix_out=0, in_ready=1; no stale pixel after reset deasserts.
